imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
- Fetch sequencer in front of instruction_memory. Owns the PC and drives imem_req/imem_addr.
- Buffers fetched words in a small prefetch FIFO and hands {pc, instr} to decode over a valid/ready handshake.
- Handles halt/resume (fetch_en) and branch/jump redirects with flush.
- instruction_memory is a combinational ROM: imem_data is valid in the same cycle as imem_req/imem_addr.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, prefetch entries. Power of 2, minimum 2.
- ADDR_WIDTH, 7, byte-address width of the attached memory. Used only for the out-of-range flag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- fetch_en  in  1  1 = fetch allowed; 0 = halt new requests.
- imem_req  out  1  memory read enable.
- imem_addr  out  32  word-aligned byte address (= PC).
- imem_data  in  32  instruction returned by memory, same cycle.
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  in  32  new fetch address.
- fetch_valid  out  1  FIFO head valid.
- fetch_instr  out  32  FIFO head instruction.
- fetch_pc  out  32  FIFO head address.
- fetch_ready  in  1  decode accepts the head.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- fetch_oor  out  1  head PC >= 2**ADDR_WIDTH (informational only).
- fetch_misalign  out  1  misaligned-redirect trap flag (see Optional Feature).

Behaviour:
- Reset values: pc=RESET_PC; FIFO empty; state=IDLE; imem_req=0; imem_addr=RESET_PC; fetch_valid=0; fetch_instr=0; fetch_pc=0; fifo_count=0; fetch_oor=0; fetch_misalign=0.
- Reset has priority over everything. Reset asserted mid-stream discards all FIFO contents.
- FSM states: IDLE, RUN, TRAP.
  - IDLE→RUN when fetch_en=1.
  - RUN→IDLE when fetch_en=0.
  - TRAP exists only with the optional feature.
- imem_req = (state==RUN) && !redirect_valid && (count<FIFO_DEPTH || pop). pop = fetch_valid && fetch_ready.
- imem_addr = pc, combinationally.
- Push on each clock edge where imem_req=1: writes {pc, imem_data}, then pc <= pc+4 (mod 2^32, wraps FFFF_FFFC→0000_0000).
- Simultaneous push and pop when full is legal; count is unchanged.
- fetch_valid = count!=0. Head fields hold stable while fetch_valid && !fetch_ready.
- Latency: fetch_en high sampled at edge N → imem_req in cycle N+1 → fetch_valid in cycle N+2. Sustained throughput is 1 word/cycle when fetch_ready=1.
- Halt (fetch_en=0): no new requests. Buffered entries are retained and still drained by decode. pc holds.
- Redirect (any state, highest priority after reset), at the edge:
  - FIFO flushed: count=0, any pop that cycle ignored.
  - pc <= redirect_pc.
  - imem_req=0 in the redirect cycle.
  - First post-redirect fetch in the next cycle (if RUN): fetch_valid for redirect_pc two cycles after the redirect pulse.
- Redirect while in IDLE: updates pc and flushes; fetching resumes from redirect_pc when fetch_en rises.
- Back-to-back redirects: the last one wins.

Optional Feature:
- Macro: IMEM_FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 loads pc, flushes the FIFO, and enters TRAP.
  - In TRAP: imem_req=0 and fetch_misalign=1 (registered, sticky).
  - Exit TRAP only by reset or an aligned redirect; the aligned redirect clears fetch_misalign and goes to RUN if fetch_en=1, else IDLE.
- Not defined: redirect_pc[1:0] is forced to 2'b00 on load; fetch_misalign is tied 0; TRAP is never entered.

Test Plan:
- Reset, fetch_en=1, fetch_ready=1, ROM words W0..W3 at 0x0..0xC → fetch_valid rises 2 cycles after fetch_en; pc/instr sequence 0x0/W0, 0x4/W1, 0x8/W2, 0xC/W3 on consecutive cycles.
- fetch_ready=0 for 5 cycles while running → fifo_count saturates at 2; imem_req low once full; head stays 0x0/W0; on release, words 0x0, 0x4, 0x8 delivered with no gap or duplicate.
- Redirect to 0x40 while FIFO holds 0x8,0xC → those entries are never presented; imem_req=0 in the pulse cycle; next head is 0x40 two cycles later.
- fetch_en dropped with 2 entries buffered → both drain; no new imem_req; re-enable resumes at the next sequential pc (0x10).
- Redirect to 0xFFFF_FFFC, run 2 words → pcs 0xFFFF_FFFC then 0x0000_0000; fetch_oor=1 on the first and 0 on the second (ADDR_WIDTH=7).
- With IMEM_FETCH_MISALIGN_TRAP_EN: redirect to 0x42 → fetch_misalign=1, imem_req stays 0 for 10 cycles; redirect to 0x44 → flag clears and fetch resumes at 0x44. Without the macro: redirect to 0x42 → fetches from 0x40.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads a combinational ROM and buffers
// {pc, instr} in a small prefetch FIFO for decode. Optional IMEM_FETCH_MISALIGN_TRAP_EN.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          ADDR_WIDTH = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fetch_en,
  output logic                            imem_req,
  output logic [31:0]                     imem_addr,
  input  logic [31:0]                     imem_data,
  input  logic                            redirect_valid,
  input  logic [31:0]                     redirect_pc,
  output logic                            fetch_valid,
  output logic [31:0]                     fetch_instr,
  output logic [31:0]                     fetch_pc,
  input  logic                            fetch_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            fetch_oor,
  output logic                            fetch_misalign
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, TRAP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        pc_mem    [FIFO_DEPTH];
  logic [31:0]        instr_mem [FIFO_DEPTH];
  logic               pop, push;
  logic [31:0]        redirect_load_pc;
  logic               redirect_misaligned;
  logic [31:0]        head_pc;

`ifdef IMEM_FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  assign redirect_load_pc    = redirect_pc;
  assign redirect_misaligned = |redirect_pc[1:0];
  assign fetch_misalign      = misalign_q;

  // Sticky until the next redirect re-evaluates alignment.
  always_ff @(posedge clk) begin
    if (rst)                 misalign_q <= 1'b0;
    else if (redirect_valid) misalign_q <= redirect_misaligned;
  end
`else
  logic unused_redirect_lsbs;

  assign redirect_load_pc     = {redirect_pc[31:2], 2'b00};
  assign redirect_misaligned  = 1'b0;
  assign fetch_misalign       = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  assign fetch_valid = (count_q != '0);
  assign pop         = fetch_valid && fetch_ready;
  assign push        = imem_req;
  assign imem_addr   = pc_q;
  assign fifo_count  = count_q;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;

    unique case (state_q)
      IDLE:    if (fetch_en)  state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase

    // A redirect overrides normal sequencing; only an aligned one leaves TRAP.
    if (redirect_valid) begin
      if (redirect_misaligned) state_d = TRAP;
      else if (fetch_en)       state_d = RUN;
      else                     state_d = IDLE;
    end

    imem_req = (state_q == RUN) && !redirect_valid && ((count_q != DEPTH_C) || pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (redirect_valid) begin
      state_q <= state_d;
      pc_q    <= redirect_load_pc;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        pc_q   <= pc_q + 32'd4;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is not reset; fetch_valid/count gate every read,
  // so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc_q;
      instr_mem[wr_ptr] <= imem_data;
    end
  end

  assign head_pc     = pc_mem[rd_ptr];
  assign fetch_pc    = fetch_valid ? head_pc : 32'd0;
  assign fetch_instr = fetch_valid ? instr_mem[rd_ptr] : 32'd0;
  assign fetch_oor   = fetch_valid && ((head_pc >> ADDR_WIDTH) != 32'd0);

endmodule
